// File: rtl/lbp_window_sched.sv
// Raster-order 3x3 window scheduler for the LBP stage: fetches interior-pixel
// neighbourhoods from gray memory, reusing two columns per horizontal step.
module lbp_window_sched #(
  parameter int W  = 128,
  parameter int H  = 128,
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            gray_ready,
  output logic            gray_req,
  output logic [AW-1:0]   gray_addr,
  input  logic [DW-1:0]   gray_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [AW-1:0]   win_addr,
  output logic [9*DW-1:0] win_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, FILL, SHIFT, EMIT} state_e;

  localparam logic [AW-1:0] WA  = AW'(W);
  localparam logic [AW-1:0] WA2 = AW'(2 * W);
  localparam logic [AW-1:0] XL  = AW'(W - 2);
  localparam logic [AW-1:0] YL  = AW'(H - 2);

  state_e        state_q, state_d;
  logic [AW-1:0] x_q, x_d, y_q, y_d, base_q, base_d;
  logic [1:0]    dx_q, dx_d, dy_q, dy_d;
  logic [DW-1:0] pix_q [9];
  logic [DW-1:0] pix_d [9];
  logic          done_q, done_d;
  logic          fetching;
  logic [3:0]    sel;
  logic [AW-1:0] row_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) pix_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
    end
  end

  // SHIFT runs with dx pinned at 2, so FILL and SHIFT share one capture and
  // completion rule: the window is full once (dx,dy) reaches (2,2).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    done_d  = done_q;
    for (int unsigned i = 0; i < 9; i++) pix_d[i] = pix_q[i];
    fetching = ((state_q == FILL) || (state_q == SHIFT)) && gray_ready;
    sel      = ({2'b00, dy_q} * 4'd3) + {2'b00, dx_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          x_d     = AW'(1);
          y_d     = AW'(1);
          base_d  = WA;
          dx_d    = '0;
          dy_d    = '0;
          done_d  = 1'b0;
        end
      end
      FILL, SHIFT: begin
        if (fetching) begin
          pix_d[sel] = gray_data;
          if (dy_q == 2'd2) begin
            dy_d = '0;
            if (dx_q == 2'd2) state_d = EMIT;
            else              dx_d    = dx_q + 2'd1;
          end else begin
            dy_d = dy_q + 2'd1;
          end
        end
      end
      EMIT: begin
        if (win_ready) begin
          if (x_q != XL) begin
            for (int unsigned r = 0; r < 3; r++) begin
              pix_d[3*r]   = pix_q[3*r+1];
              pix_d[3*r+1] = pix_q[3*r+2];
            end
            x_d     = x_q + AW'(1);
            dx_d    = 2'd2;
            dy_d    = '0;
            state_d = SHIFT;
          end else if (y_q != YL) begin
            x_d     = AW'(1);
            y_d     = y_q + AW'(1);
            base_d  = base_q + WA;
            dx_d    = '0;
            dy_d    = '0;
            state_d = FILL;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (dy_q)
      2'd0:    row_off = '0;
      2'd1:    row_off = WA;
      default: row_off = WA2;
    endcase
  end

  // Fetch address is (y-1+dy)*W + (x-1+dx), built from the running row base.
  always_comb begin
    gray_req  = fetching;
    gray_addr = '0;
    if ((state_q == FILL) || (state_q == SHIFT))
      gray_addr = base_q - WA + row_off + x_q - AW'(1) + {{(AW-2){1'b0}}, dx_q};
    win_valid = (state_q == EMIT);
    win_addr  = (state_q == EMIT) ? (base_q + x_q) : '0;
    for (int unsigned i = 0; i < 9; i++) win_data[DW*i +: DW] = pix_q[i];
    busy = (state_q != IDLE);
    done = done_q;
  end

endmodule

// File: tb/tb_lbp_window_sched.sv
// Directed bench for lbp_window_sched on a ramp image; fetch addresses and
// windows are checked against a queue scoreboard built from a software extract.
module tb_lbp_window_sched;
  localparam int W  = 128;
  localparam int H  = 128;
  localparam int AW = 14;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            gray_ready = 1'b1;
  logic            gray_req;
  logic [AW-1:0]   gray_addr;
  logic [DW-1:0]   gray_data;
  logic            win_valid;
  logic            win_ready = 1'b1;
  logic [AW-1:0]   win_addr;
  logic [9*DW-1:0] win_data;
  logic            busy;
  logic            done;

  lbp_window_sched #(.W(W), .H(H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_addr(win_addr),
    .win_data(win_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Ramp image: gray[y*W+x] = (x+y) & 0xFF
  assign gray_data = DW'((int'(gray_addr) % W) + (int'(gray_addr) / W));

  typedef struct {
    logic [AW-1:0]   a;
    logic [9*DW-1:0] d;
  } win_t;

  logic [AW-1:0] exp_fetch[$];
  win_t          exp_win[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            win_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  bit            mon_en = 1'b0;
  logic [9*DW-1:0] first_win;
  int            n;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {gray_req, gray_addr, win_valid, win_addr, win_data, busy, done}, '0);
  endtask

  function automatic logic [DW-1:0] pix(input int x, input int y);
    return DW'((x + y) & 255);
  endfunction

  task automatic push_frame();
    win_t w;
    exp_fetch.delete();
    exp_win.delete();
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        for (int c = (x == 1) ? -1 : 1; c <= 1; c++)
          for (int r = -1; r <= 1; r++)
            exp_fetch.push_back(AW'((y + r) * W + (x + c)));
        w.a = AW'(y * W + x);
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            w.d[DW*(3*dy+dx) +: DW] = pix(x - 1 + dx, y - 1 + dy);
        exp_win.push_back(w);
      end
    end
  endtask

  task automatic monitor();
    win_t w;
    if (!mon_en) return;
    if (gray_req) begin
      vectors++;
      assert (exp_fetch.size() > 0) else begin
        miscompares++;
        $error("FAIL fetch_unexpected observed=%0d expected=none", gray_addr);
      end
      if (exp_fetch.size() > 0) chk("fetch_addr", gray_addr, exp_fetch.pop_front());
    end
    if (win_valid && win_ready) begin
      vectors++;
      assert (exp_win.size() > 0) else begin
        miscompares++;
        $error("FAIL win_unexpected observed=%0d expected=none", win_addr);
      end
      if (exp_win.size() > 0) begin
        w = exp_win.pop_front();
        chk("win_addr", win_addr, w.a);
        chk("win_data", win_data, w.d);
      end
      win_cnt++;
      last_waddr = win_addr;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_hold");
    reset = 1'b0;
    cyc();
    check_idle("idle_after_reset");

    // Frame 1: first window, backpressure, ignored start, abort at window 5000
    push_frame();
    win_ready = 1'b0;
    mon_en = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("first_req", {gray_req, gray_addr}, {1'b1, 14'd0});
    for (n = 0; n < 50 && !win_valid; n++) cyc();
    chk("first_win_latency", n, 9);
    chk("first_win_addr", win_addr, 129);
    chk("first_win_byte0", win_data[7:0], 0);
    chk("first_win_byte4", win_data[39:32], 2);
    chk("first_win_byte8", win_data[71:64], 4);
    first_win = win_data;
    repeat (5) begin
      cyc();
      chk("bp_valid", win_valid, 1);
      chk("bp_addr", win_addr, 129);
      chk("bp_data", win_data, first_win);
      chk("bp_no_req", gray_req, 0);
    end
    win_ready = 1'b1;
    cyc();
    chk("shift_first_req", {gray_req, gray_addr}, {1'b1, 14'd3});
    for (n = 0; n < 50 && !win_valid; n++) cyc();
    chk("second_win_addr", win_addr, 130);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    for (n = 0; n < 30000 && win_cnt < 5000; n++) cyc();
    chk("reached_win_5000", win_cnt, 5000);
    #2;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_idle("async_reset_mid_frame");
    @(posedge clk);
    #1;
    check_idle("reset_held_idle");
    reset = 1'b0;

    // Frame 2: restart from (1,1) with a fetch stall after the 4th FILL read
    push_frame();
    win_cnt = 0;
    mon_en = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_first_req", {gray_req, gray_addr}, {1'b1, 14'd0});
    repeat (3) cyc();
    chk("fourth_read_addr", {gray_req, gray_addr}, {1'b1, 14'd1});
    cyc();
    gray_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_no_req", gray_req, 0);
      chk("stall_addr_held", gray_addr, 129);
      cyc();
    end
    gray_ready = 1'b1;
    #1;
    chk("resume_req", {gray_req, gray_addr}, {1'b1, 14'd129});
    for (n = 0; n < 50 && !win_valid; n++) cyc();
    chk("stall_win_addr", win_addr, 129);
    chk("stall_win_same", win_data, first_win);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cyc();

    // Frame 3: complete frame with both ready inputs high
    push_frame();
    win_cnt = 0;
    mon_en = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (n = 0; n < 70000 && !done; n++) cyc();
    chk("frame_cycles", n, 64260);
    chk("frame_windows", win_cnt, 15876);
    chk("last_win_addr", last_waddr, 16254);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("fetch_queue_drained", exp_fetch.size(), 0);
    chk("win_queue_drained", exp_win.size(), 0);
    mon_en = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_cleared_by_start", {busy, done}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
